fetch_unit: RTL

Instruction fetch stage sitting upstream of the IF/ID buffer in the pipelined datapath. It owns the program counter and issues word-addressed requests to instruction memory over a request/response handshake. Returned instructions are buffered in a small prefetch FIFO and presented to ID with a valid/ready handshake. A taken branch or jump from WB causes a redirect that flushes the FIFO and discards in-flight responses.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Instruction memory and IF/ID handshake bundle for fetch_unit
// master is the fetch stage; slave is the memory/decode environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage with credit-limited prefetch FIFO
// Owns the PC, issues in-order imem requests, and drops in-flight responses after a redirect.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CR_MAX = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic        pop, pop_eff, accept, rsp, push;
  logic [CW:0] credits_used;

  assign pop          = bus.if_valid && bus.id_ready;
  assign pop_eff      = pop && !bus.redirect;
  assign accept       = bus.imem_req && bus.imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp          = bus.imem_rvalid && (out_cnt_q != '0);
  assign push         = rsp && (drop_cnt_q == '0) && !bus.redirect;
  assign credits_used = {1'b0, out_cnt_q} + {1'b0, cnt_q} - (CW+1)'(pop);

  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = (cnt_q != '0);
  assign bus.if_pc     = pc_mem_q[rd_ptr_q];
  assign bus.if_instr  = instr_mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      state_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   state_d = FETCH;
        FLUSH:   if (drop_cnt_q == '0) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req = 1'b0;
    if (state_q == FETCH) bus.imem_req = (credits_used < CR_MAX);
  end

  always_comb begin
    out_cnt_d   = out_cnt_q + CW'(accept) - CW'(rsp);
    drop_cnt_d  = drop_cnt_q;
    fetch_pc_d  = accept ? fetch_pc_q + 32'd1 : fetch_pc_q;
    resp_pc_d   = push ? resp_pc_q + 32'd1 : resp_pc_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop_eff);
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_eff ? rd_ptr_q + AW'(1) : rd_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    if (push) begin
      pc_mem_d[wr_ptr_q]    = resp_pc_q;
      instr_mem_d[wr_ptr_q] = bus.imem_rdata;
    end
    // Redirect wins: everything still in flight after this edge must be discarded.
    if (bus.redirect) begin
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      if (state_q != FLUSH) drop_cnt_d = out_cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q  <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      out_cnt_q   <= out_cnt_d;
      cnt_q       <= cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end
endmodule
